// File: rtl/instr_loader.sv
// instr_loader: receives a framed program over a valid/ready byte stream
// and writes it into a 256 x 12 instruction store. The processor is held
// in reset until a frame passes its checksum.
//
// Frame: HDR, N (0 means 256), N pairs {HI, LO}, checksum.
// The checksum is the XOR of N and every HI and LO byte.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   rx_valid   : byte-stream valid
//   rx_data    : byte-stream data
//   rx_ready   : byte-stream ready; a byte moves on an edge with valid & ready
//   instr_addr : processor fetch address
//   instr      : store[instr_addr], combinational read
//   proc_rst   : processor hold-in-reset (low only while running)
//   load_done  : program loaded, processor running
//   load_err   : last frame rejected
module instr_loader #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [7:0]  instr_addr,
  output logic [11:0] instr,
  output logic        proc_rst,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    CSUM  = 3'd4,
    RUN   = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  wa_r;
  logic [8:0]  rem_r;
  logic [7:0]  cs_r;
  logic [3:0]  hi_r;
  logic        rx_ready_r;
  logic        proc_rst_r;
  logic        load_done_r;
  logic        load_err_r;
  logic        accept_s;
  logic [11:0] store_r [256];

  // Running XOR checksum over the frame body.
  function automatic logic [7:0] csum_update(input logic [7:0] cs,
                                             input logic [7:0] b);
    return cs ^ b;
  endfunction

  assign accept_s  = rx_valid & rx_ready_r;
  assign rx_ready  = rx_ready_r;
  assign proc_rst  = proc_rst_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;
  assign instr     = store_r[instr_addr];

  // Next-state decode; the state only moves on an accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      case (state_r)
        IDLE, RUN, ERR: begin
          if (rx_data == HDR) begin
            state_nxt_s = COUNT;
          end else begin
            state_nxt_s = state_r;
          end
        end
        COUNT: state_nxt_s = HI;
        HI: begin
          if (rx_data[7:4] != 4'h0) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = LO;
          end
        end
        LO: begin
          // rem_r is the count before this pair completes.
          if (rem_r == 9'd1) begin
            state_nxt_s = CSUM;
          end else begin
            state_nxt_s = HI;
          end
        end
        CSUM: begin
          if (rx_data == cs_r) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = ERR;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Loader FSM, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      wa_r        <= 8'd0;
      rem_r       <= 9'd0;
      cs_r        <= 8'd0;
      hi_r        <= 4'd0;
      rx_ready_r  <= 1'b0;
      proc_rst_r  <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      rx_ready_r  <= 1'b1;
      state_r     <= state_nxt_s;
      // Flags follow the next state so they line up with the state register.
      proc_rst_r  <= (state_nxt_s != RUN);
      load_done_r <= (state_nxt_s == RUN);
      load_err_r  <= (state_nxt_s == ERR);
      if (accept_s) begin
        case (state_r)
          IDLE, RUN, ERR: begin
            if (rx_data == HDR) begin
              wa_r <= 8'd0;
              cs_r <= 8'd0;
            end else begin
              wa_r <= wa_r;
              cs_r <= cs_r;
            end
          end
          COUNT: begin
            rem_r <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            cs_r  <= csum_update(cs_r, rx_data);
          end
          HI: begin
            cs_r <= csum_update(cs_r, rx_data);
            if (rx_data[7:4] == 4'h0) begin
              hi_r <= rx_data[3:0];
            end else begin
              hi_r <= hi_r;
            end
          end
          LO: begin
            wa_r  <= wa_r + 8'd1;
            rem_r <= rem_r - 9'd1;
            cs_r  <= csum_update(cs_r, rx_data);
          end
          CSUM: begin
            cs_r <= cs_r;
          end
          default: begin
            cs_r <= cs_r;
          end
        endcase
      end else begin
        cs_r <= cs_r;
      end
    end
  end

  // Instruction store write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (accept_s && (state_r == LO)) begin
      store_r[wa_r] <= {hi_r, rx_data};
    end else begin
      store_r[wa_r] <= store_r[wa_r];
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  instr_addr;
  logic [11:0] instr;
  logic        proc_rst;
  logic        load_done;
  logic        load_err;

  int vectors;
  int miscompares;

  instr_loader #(.HDR(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .instr_addr (instr_addr),
    .instr      (instr),
    .proc_rst   (proc_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic pr,
                              input logic ld, input logic le);
    check({tag, ".proc_rst"}, {11'd0, proc_rst}, {11'd0, pr});
    check({tag, ".load_done"}, {11'd0, load_done}, {11'd0, ld});
    check({tag, ".load_err"}, {11'd0, load_err}, {11'd0, le});
  endtask

  // Present one byte, wait (bounded) for ready, let one edge accept it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      check("ready_wait", {11'd0, rx_ready}, 12'd1);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  // XOR of everything after the header byte.
  function automatic logic [7:0] body_xor(input logic [7:0] q[$]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < q.size(); i++) x = x ^ q[i];
    return x;
  endfunction

  task automatic read_check(input string tag, input logic [7:0] a,
                            input logic [11:0] exp);
    instr_addr = a;
    #1;
    check(tag, instr, exp);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] good_cs;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    instr_addr  = 8'h00;

    // Reset values, before any clock edge.
    #1;
    check("rst.rx_ready", {11'd0, rx_ready}, 12'd0);
    check_status("rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel.rx_ready", {11'd0, rx_ready}, 12'd1);
    check_status("idle", 1'b1, 1'b0, 1'b0);

    // Two-word frame: checksum 02^01^23^0F^FF = D0.
    fr = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF};
    good_cs = body_xor(fr);
    check("csum_model", {4'd0, good_cs}, 12'h0D0);
    send_bytes(fr);
    check_status("pre_csum", 1'b1, 1'b0, 1'b0);
    send_byte(good_cs);
    check_status("run1", 1'b0, 1'b1, 1'b0);
    read_check("store0", 8'd0, 12'h123);
    read_check("store1", 8'd1, 12'hFFF);
    check_status("addr_no_effect", 1'b0, 1'b1, 1'b0);

    // Same frame, bad checksum, then the correct one again.
    send_bytes(fr);
    check_status("restart_from_run", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00);
    check_status("bad_csum", 1'b1, 1'b0, 1'b1);
    send_bytes(fr);
    send_byte(good_cs);
    check_status("run2", 1'b0, 1'b1, 1'b0);

    // In RUN, non-header bytes are ignored; header drops to COUNT.
    send_byte(8'h11);
    check_status("run_ign11", 1'b0, 1'b1, 1'b0);
    send_byte(8'h22);
    check_status("run_ign22", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    check_status("run_hdr", 1'b1, 1'b0, 1'b0);

    // Bad HI byte (upper nibble 3) -> ERR; trailing bytes discarded.
    send_byte(8'h01);
    check_status("count", 1'b1, 1'b0, 1'b0);
    send_byte(8'h31);
    check_status("hi_err", 1'b1, 1'b0, 1'b1);
    send_byte(8'h00);
    check_status("err_ign00", 1'b1, 1'b0, 1'b1);
    send_byte(8'h7E);
    check_status("err_ign7E", 1'b1, 1'b0, 1'b1);

    // N=0 -> 256 pairs, data = address; includes A5 as a data byte.
    fr = '{8'hA5, 8'h00};
    for (int k = 0; k < 256; k++) begin
      fr.push_back(8'h00);
      fr.push_back(k[7:0]);
    end
    good_cs = body_xor(fr);
    send_bytes(fr);
    check_status("full_pre_csum", 1'b1, 1'b0, 1'b0);
    send_byte(good_cs);
    check_status("run_full", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++) begin
      read_check("store_full", k[7:0], {4'd0, k[7:0]});
    end

    // Reset after the 3rd byte of a frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst.rx_ready", {11'd0, rx_ready}, 12'd0);
    check_status("mid_rst", 1'b1, 1'b0, 1'b0);
    read_check("store_kept", 8'd5, 12'h005);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel2.rx_ready", {11'd0, rx_ready}, 12'd1);
    check_status("post_rst", 1'b1, 1'b0, 1'b0);
    // 01^04^56 = 53
    fr = '{8'hA5, 8'h01, 8'h04, 8'h56};
    good_cs = body_xor(fr);
    check("csum_model2", {4'd0, good_cs}, 12'h053);
    send_bytes(fr);
    send_byte(good_cs);
    check_status("run3", 1'b0, 1'b1, 1'b0);
    read_check("store_after_rst", 8'd0, 12'h456);
    read_check("store_untouched", 8'd1, 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
